lcd1602_driver: RTL

//  Downstream consumer of the display FSM's row1/row2 text buffers (16 ASCII chars each, MSB byte = leftmost).

---
 rtl/lcd1602_driver.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/lcd1602_driver.sv
// HD44780 16x2 write-only driver: power-on wait and init command list, then an
// endless refresh of both lines from row1/row2 snapshots taken once per frame.
module lcd1602_driver #(
  parameter int POWERON_CYC = 200000,
  parameter int EN_CYC      = 5,
  parameter int WAIT_CYC    = 500,
  parameter int CLEAR_CYC   = 20000
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic [127:0] row1,
  input  logic [127:0] row2,
  output logic         lcd_en,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic [7:0]   lcd_data,
  output logic         init_done,
  output logic         frame_done
);
  localparam int MAX_A = (POWERON_CYC > CLEAR_CYC) ? POWERON_CYC : CLEAR_CYC;
  localparam int MAX_C = (MAX_A > WAIT_CYC) ? MAX_A : WAIT_CYC;
  localparam int CW    = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {POWERON, INIT, L1_ADDR, L1_CHAR, L2_ADDR, L2_CHAR} state_e;
  typedef enum logic [1:0] {SETUP, PULSE, HOLD} phase_e;

  state_e        st_q, st_d;
  phase_e        ph_q, ph_d;
  logic [CW-1:0] cnt_q, cnt_d, hold_last;
  logic [3:0]    idx_q, idx_d, idx_inc;
  logic [6:0]    sel_inc;
  logic [127:0]  snap1_q, snap1_d, snap2_q, snap2_d;
  logic [7:0]    data_q, data_d;
  logic          en_q, en_d, rs_q, rs_d;
  logic          init_done_q, init_done_d, frame_done_q, frame_done_d;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction

  // Column c of a row lives at bits [127-8c -: 8]; 15-c is just ~c for 4 bits.
  assign idx_inc   = idx_q + 4'd1;
  assign sel_inc   = {~idx_inc, 3'b000};
  assign hold_last = (!rs_q && data_q == 8'h01) ? CW'(CLEAR_CYC - 1) : CW'(WAIT_CYC - 1);

  always_comb begin
    st_d        = st_q;
    ph_d        = ph_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    snap1_d     = snap1_q;
    snap2_d     = snap2_q;
    data_d      = data_q;
    en_d        = en_q;
    rs_d        = rs_q;
    init_done_d = init_done_q;
    if (st_q == POWERON) begin
      if (cnt_q == CW'(POWERON_CYC - 1)) begin
        st_d   = INIT;
        ph_d   = SETUP;
        cnt_d  = '0;
        idx_d  = '0;
        rs_d   = 1'b0;
        data_d = 8'h38;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      case (ph_q)
        SETUP: begin
          ph_d  = PULSE;
          en_d  = 1'b1;
          cnt_d = '0;
          if (st_q == L1_ADDR) begin
            snap1_d = row1;
            snap2_d = row2;
          end
        end
        PULSE: begin
          if (cnt_q == CW'(EN_CYC - 1)) begin
            ph_d  = HOLD;
            en_d  = 1'b0;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          if (cnt_q != hold_last) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            ph_d  = SETUP;
            cnt_d = '0;
            case (st_q)
              INIT: begin
                if (idx_q == 4'd3) begin
                  st_d        = L1_ADDR;
                  rs_d        = 1'b0;
                  data_d      = 8'h80;
                  init_done_d = 1'b1;
                end else begin
                  idx_d  = idx_inc;
                  data_d = init_cmd(idx_inc[1:0]);
                end
              end
              L1_ADDR: begin
                st_d   = L1_CHAR;
                idx_d  = '0;
                rs_d   = 1'b1;
                data_d = snap1_q[127:120];
              end
              L1_CHAR: begin
                if (idx_q == 4'd15) begin
                  st_d   = L2_ADDR;
                  rs_d   = 1'b0;
                  data_d = 8'hC0;
                end else begin
                  idx_d  = idx_inc;
                  data_d = snap1_q[sel_inc +: 8];
                end
              end
              L2_ADDR: begin
                st_d   = L2_CHAR;
                idx_d  = '0;
                rs_d   = 1'b1;
                data_d = snap2_q[127:120];
              end
              L2_CHAR: begin
                if (idx_q == 4'd15) begin
                  st_d   = L1_ADDR;
                  rs_d   = 1'b0;
                  data_d = 8'h80;
                end else begin
                  idx_d  = idx_inc;
                  data_d = snap2_q[sel_inc +: 8];
                end
              end
              default: st_d = POWERON;
            endcase
          end
        end
      endcase
    end
    // Registered pulse lands on the final HOLD cycle of the last line-2 char.
    frame_done_d = (st_d == L2_CHAR) && (idx_d == 4'd15) && (ph_d == HOLD) &&
                   (cnt_d == CW'(WAIT_CYC - 1));
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      st_q         <= POWERON;
      ph_q         <= SETUP;
      cnt_q        <= '0;
      idx_q        <= '0;
      snap1_q      <= {16{8'h20}};
      snap2_q      <= {16{8'h20}};
      data_q       <= 8'h00;
      en_q         <= 1'b0;
      rs_q         <= 1'b0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      st_q         <= st_d;
      ph_q         <= ph_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap1_q      <= snap1_d;
      snap2_q      <= snap2_d;
      data_q       <= data_d;
      en_q         <= en_d;
      rs_q         <= rs_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign lcd_en     = en_q;
  assign lcd_rs     = rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_data   = data_q;
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;
endmodule
